hdmi_i2c_config: RTL and testbench

- Power-up and hot-plug configuration sequencer for the HDMI transmitter behind the parallel video port.
- Walks a fixed table of {register, value} pairs and writes each pair to the transmitter over an open-drain I2C master.
- Reports progress and errors; re-runs the sequence on every hot-plug assertion or on a software/debug start pulse.

---
 rtl/hdmi_cfg_pkg.sv | 27 ++
 rtl/hdmi_cfg_rom.sv | 25 ++
 rtl/hdmi_i2c_config.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_hdmi_i2c_config.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_cfg_pkg.sv
// Shared definitions for the HDMI transmitter configuration sequencer:
// table size, index width, FSM state encoding and the register table.
package hdmi_cfg_pkg;

    localparam int NUM_ENTRIES = 12;
    localparam int IDX_W       = $clog2(NUM_ENTRIES + 1);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_WAIT  = 4'd1,
        ST_START = 4'd2,
        ST_BYTE  = 4'd3,
        ST_ACK   = 4'd4,
        ST_STOP  = 4'd5,
        ST_NEXT  = 4'd6,
        ST_DONE  = 4'd7,
        ST_FAIL  = 4'd8
    } state_t;

    // {register, value} pairs, written in this order.
    localparam logic [15:0] CFG_TABLE [NUM_ENTRIES] = '{
        16'h41_10, 16'h98_03, 16'h9A_E0, 16'h9C_30,
        16'h9D_61, 16'hA2_A4, 16'hA3_A4, 16'hE0_D0,
        16'hF9_00, 16'h15_00, 16'h16_30, 16'hAF_04
    };

endpackage

// File: rtl/hdmi_cfg_rom.sv
// Combinational lookup of one {register, value} pair by table index.
// Indices past the end of the table return zero.
module hdmi_cfg_rom
    import hdmi_cfg_pkg::*;
(
    input  logic [IDX_W-1:0] idx_i,
    output logic [7:0]       reg_o,
    output logic [7:0]       val_o
);

    logic [15:0] entry;

    // Table read with a safe default for out-of-range indices.
    always_comb begin
        // NOTE: assigning a default before any condition keeps this purely combinational (no latch).
        entry = 16'h0000;
        if (idx_i < IDX_W'(NUM_ENTRIES)) begin
            entry = CFG_TABLE[idx_i];
        end
    end

    assign reg_o = entry[15:8];
    assign val_o = entry[7:0];

endmodule

// File: rtl/hdmi_i2c_config.sv
// Power-up / hot-plug configuration sequencer for the HDMI transmitter.
// Walks the register table and writes each pair over an open-drain I2C
// master (address, register, value), retrying NACKed entries.
module hdmi_i2c_config
    import hdmi_cfg_pkg::*;
#(
    parameter int         QDIV      = 36,
    parameter logic [6:0] DEV_ADDR  = 7'h39,
    parameter int         PWRUP_CYC = 14318,
    parameter int         MAX_RETRY = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic hpd,
    input  logic start,
    input  logic sda_i,
    output logic scl_oe,
    output logic sda_oe,
    output logic busy,
    output logic done,
    output logic nack_err,
    output logic fail
);

    localparam int DIV_W  = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam int WAIT_W = $clog2(PWRUP_CYC + 1);

    // Input synchronisers.
    logic hpd_meta_q, hpd_sync_q, hpd_prev_q;
    logic sda_meta_q, sda_sync_q;

    // Sequencer state.
    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [1:0]         qtr_q, qtr_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         retry_q, retry_d;
    logic [1:0]         byte_q, byte_d;
    logic [2:0]         bit_q, bit_d;
    logic               ent_nack_q, ent_nack_d;
    logic               abort_q, abort_d;
    logic               scl_oe_q, scl_oe_d;
    logic               sda_oe_q, sda_oe_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               nack_q, nack_d;
    logic               fail_q, fail_d;

    logic [7:0] rom_reg, rom_val;
    logic [7:0] cur_byte;
    logic       cur_bit;
    logic       tick;
    logic       idle_like;
    logic       hpd_rise, hpd_fall;
    logic       trigger;

    hdmi_cfg_rom u_rom (
        .idx_i (idx_q),
        .reg_o (rom_reg),
        .val_o (rom_val)
    );

    assign hpd_rise  = hpd_sync_q & ~hpd_prev_q;
    assign hpd_fall  = ~hpd_sync_q & hpd_prev_q;
    assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_FAIL);
    assign trigger   = idle_like && (hpd_rise || start);
    assign tick      = (div_q == DIV_W'(QDIV - 1));

    // Byte 0 is the write address, then register, then value; MSB first.
    assign cur_byte = (byte_q == 2'd0) ? {DEV_ADDR, 1'b0} :
                      (byte_q == 2'd1) ? rom_reg : rom_val;
    assign cur_bit  = cur_byte[~bit_q];

    // Double-flop the asynchronous hpd and SDA inputs; keep last hpd for edge detect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hpd_meta_q <= 1'b0;
            hpd_sync_q <= 1'b0;
            hpd_prev_q <= 1'b0;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its source.
            hpd_meta_q <= hpd;
            hpd_sync_q <= hpd_meta_q;
            hpd_prev_q <= hpd_sync_q;
            sda_meta_q <= sda_i;
            sda_sync_q <= sda_meta_q;
        end
    end

    // Next-state logic: quarter-bit divider, bus phase actions and table walk.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        qtr_d      = qtr_q;
        wait_d     = wait_q;
        idx_d      = idx_q;
        retry_d    = retry_q;
        byte_d     = byte_q;
        bit_d      = bit_q;
        ent_nack_d = ent_nack_q;
        abort_d    = abort_q;
        scl_oe_d   = scl_oe_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        done_d     = done_q;
        nack_d     = nack_q;
        fail_d     = fail_q;

        if (idle_like) begin
            div_d = '0;
            qtr_d = '0;
        end else if (tick) begin
            div_d = '0;
            qtr_d = qtr_q + 2'd1;
        end else begin
            div_d = div_q + 1'b1;
        end

        // Losing the sink drops done at once; a run in progress finishes its transaction first.
        if (hpd_fall) begin
            done_d = 1'b0;
            if (busy_q) abort_d = 1'b1;
        end

        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (trigger) begin
                    state_d  = ST_WAIT;
                    wait_d   = '0;
                    idx_d    = '0;
                    retry_d  = '0;
                    abort_d  = 1'b0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    nack_d   = 1'b0;
                    fail_d   = 1'b0;
                end
            end
            ST_WAIT: begin
                if (abort_q) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (wait_q == WAIT_W'(PWRUP_CYC - 1)) begin
                    state_d = ST_START;
                    div_d   = '0;
                    qtr_d   = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    case (qtr_q)
                        2'd0, 2'd1: begin
                            sda_oe_d = 1'b0;
                            scl_oe_d = 1'b0;
                        end
                        2'd2: sda_oe_d = 1'b1;
                        default: begin
                            scl_oe_d = 1'b1;
                            state_d  = ST_BYTE;
                            byte_d   = 2'd0;
                            bit_d    = 3'd0;
                        end
                    endcase
                end
            end
            ST_BYTE: begin
                if (tick) begin
                    case (qtr_q)
                        2'd0: sda_oe_d = ~cur_bit;
                        2'd1: scl_oe_d = 1'b0;
                        2'd2: ;
                        default: begin
                            scl_oe_d = 1'b1;
                            if (bit_q == 3'd7) begin
                                state_d = ST_ACK;
                                bit_d   = 3'd0;
                            end else begin
                                bit_d = bit_q + 3'd1;
                            end
                        end
                    endcase
                end
            end
            ST_ACK: begin
                if (tick) begin
                    case (qtr_q)
                        2'd0: sda_oe_d = 1'b0;
                        2'd1: scl_oe_d = 1'b0;
                        2'd2: ent_nack_d = sda_sync_q;
                        default: begin
                            scl_oe_d = 1'b1;
                            if (ent_nack_q) begin
                                nack_d  = 1'b1;
                                state_d = ST_STOP;
                            end else if (byte_q == 2'd2) begin
                                state_d = ST_STOP;
                            end else begin
                                byte_d  = byte_q + 2'd1;
                                state_d = ST_BYTE;
                            end
                        end
                    endcase
                end
            end
            ST_STOP: begin
                if (tick) begin
                    case (qtr_q)
                        2'd0: sda_oe_d = 1'b1;
                        2'd1: scl_oe_d = 1'b0;
                        2'd2: sda_oe_d = 1'b0;
                        default: state_d = ST_NEXT;
                    endcase
                end
            end
            ST_NEXT: begin
                // One full bit time of bus-free gap before deciding.
                if (tick && (qtr_q == 2'd3)) begin
                    if (abort_q) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b0;
                    end else if (ent_nack_q) begin
                        if ((3'(retry_q) + 3'd1) == 3'(MAX_RETRY)) begin
                            state_d = ST_FAIL;
                            busy_d  = 1'b0;
                            fail_d  = 1'b1;
                        end else begin
                            retry_d = retry_q + 2'd1;
                            state_d = ST_START;
                        end
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        retry_d = '0;
                        if ((idx_q + 1'b1) == IDX_W'(NUM_ENTRIES)) begin
                            state_d = ST_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_START;
                        end
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                busy_d   = 1'b0;
                scl_oe_d = 1'b0;
                sda_oe_d = 1'b0;
            end
        endcase
    end

    // Sequencer registers; reset releases both bus lines immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            qtr_q      <= '0;
            wait_q     <= '0;
            idx_q      <= '0;
            retry_q    <= '0;
            byte_q     <= '0;
            bit_q      <= '0;
            ent_nack_q <= 1'b0;
            abort_q    <= 1'b0;
            scl_oe_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            nack_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            qtr_q      <= qtr_d;
            wait_q     <= wait_d;
            idx_q      <= idx_d;
            retry_q    <= retry_d;
            byte_q     <= byte_d;
            bit_q      <= bit_d;
            ent_nack_q <= ent_nack_d;
            abort_q    <= abort_d;
            scl_oe_q   <= scl_oe_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            nack_q     <= nack_d;
            fail_q     <= fail_d;
        end
    end

    assign scl_oe   = scl_oe_q;
    assign sda_oe   = sda_oe_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign nack_err = nack_q;
    assign fail     = fail_q;

endmodule

// File: tb/tb_hdmi_i2c_config.sv
// Bench for hdmi_i2c_config: an I2C slave model records each transaction
// between START and STOP, ACKs or NACKs on demand, and a line checker
// watches SCL high/low times and START/STOP framing.
module tb_hdmi_i2c_config;

    localparam int QDIV      = 4;
    localparam int PWRUP_CYC = 50;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic hpd = 1'b0;
    logic start = 1'b0;
    logic sda_i;
    logic scl_oe, sda_oe, busy, done, nack_err, fail;

    hdmi_i2c_config #(
        .QDIV      (QDIV),
        .DEV_ADDR  (7'h39),
        .PWRUP_CYC (PWRUP_CYC),
        .MAX_RETRY (3)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .hpd      (hpd),
        .start    (start),
        .sda_i    (sda_i),
        .scl_oe   (scl_oe),
        .sda_oe   (sda_oe),
        .busy     (busy),
        .done     (done),
        .nack_err (nack_err),
        .fail     (fail)
    );

    always #5 clk = ~clk;

    // Hand-written copy of the expected table.
    logic [15:0] exp_tab [12] = '{
        16'h4110, 16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61, 16'hA2A4,
        16'hA3A4, 16'hE0D0, 16'hF900, 16'h1500, 16'h1630, 16'hAF04
    };

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // ---------------- I2C slave model ----------------
    logic        scl, sda_line;
    logic        sl_drv = 1'b0;
    logic        scl_p = 1'b1, sda_p = 1'b1;
    logic        in_txn = 1'b0;
    int          bitc = 0;
    int          bytec = 0;
    logic [7:0]  sh = 8'h00;
    logic [7:0]  b0 = 8'h00, b1 = 8'h00, b2 = 8'h00;
    int          mode = 0;        // 0 ack all, 1 nack value of reg 9A once, 2 nack address always
    logic        nacked_once = 1'b0;
    logic        nack_now;
    int          fviol = 0;       // framing violations
    logic [23:0] txq [$];

    assign scl      = ~scl_oe;
    assign sda_line = ~(sda_oe | sl_drv);
    assign sda_i    = sda_line;
    assign nack_now = (mode == 2 && bytec == 0) ||
                      (mode == 1 && bytec == 2 && b1 == 8'h9A && !nacked_once);

    always @(negedge clk) begin
        scl_p <= scl;
        sda_p <= sda_line;
        if (scl && scl_p && sda_p && !sda_line) begin
            if (in_txn) fviol <= fviol + 1;
            in_txn <= 1'b1;
            bitc   <= 0;
            bytec  <= 0;
            b0 <= 8'h00; b1 <= 8'h00; b2 <= 8'h00;
            sl_drv <= 1'b0;
        end else if (scl && scl_p && !sda_p && sda_line) begin
            if (!in_txn) fviol <= fviol + 1;
            else txq.push_back({b0, b1, b2});
            in_txn <= 1'b0;
        end else if (in_txn && scl && !scl_p) begin
            if (bitc < 8) sh <= {sh[6:0], sda_line};
            bitc <= bitc + 1;
        end else if (in_txn && !scl && scl_p) begin
            if (bitc == 8) begin
                case (bytec)
                    0: b0 <= sh;
                    1: b1 <= sh;
                    default: b2 <= sh;
                endcase
                sl_drv <= ~nack_now;
                if (nack_now && mode == 1) nacked_once <= 1'b1;
            end else if (bitc == 9) begin
                sl_drv <= 1'b0;
                bitc   <= 0;
                bytec  <= bytec + 1;
            end
        end
    end

    // ---------------- SCL timing checker ----------------
    logic tchk_en = 1'b1;
    int   run_len = 1;
    int   tviol = 0;
    logic scl_t = 1'b1;

    always @(negedge clk) begin
        scl_t <= scl;
        if (scl != scl_t) begin
            if (tchk_en && run_len < 2 * QDIV) tviol <= tviol + 1;
            run_len <= 1;
        end else begin
            run_len <= run_len + 1;
        end
    end

    // ---------------- helpers ----------------
    logic [23:0] exp_q [$];

    task automatic exp_run(input int dup);
        exp_q.delete();
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back({8'h72, exp_tab[i]});
            if (i == dup) exp_q.push_back({8'h72, exp_tab[i]});
        end
    endtask

    task automatic cmp_txns(input string tag);
        check({tag, "_ntx"}, txq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < txq.size()) check($sformatf("%s_tx%0d", tag, i), txq[i], exp_q[i]);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        repeat (8) @(negedge clk);
        for (int i = 0; i < budget; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check({tag, "_idle_in_time"}, busy, 1'b0);
        repeat (4) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", {scl_oe, sda_oe, busy, done, nack_err, fail}, 6'b0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // 1: hot-plug, everything ACKed
        hpd = 1'b1;
        repeat (10) @(negedge clk);
        check("t1_busy_in_wait", busy, 1'b1);
        repeat (30) @(negedge clk);
        check("t1_quiet_in_wait", {scl_oe, sda_oe, 24'(txq.size())}, 26'b0);
        wait_idle("t1", 20000);
        exp_run(-1);
        cmp_txns("t1");
        check("t1_flags", {busy, done, nack_err, fail}, 4'b0100);
        check("t1_lines", {scl_oe, sda_oe}, 2'b00);

        // 2: value byte of register 9A NACKed once, then retried
        txq.delete();
        mode = 1;
        pulse_start();
        wait_idle("t2", 20000);
        exp_run(2);
        cmp_txns("t2");
        check("t2_flags", {busy, done, nack_err, fail}, 4'b0110);

        // 3: address always NACKed -> three attempts then fail
        txq.delete();
        mode = 2;
        pulse_start();
        wait_idle("t3", 20000);
        check("t3_ntx", txq.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < txq.size()) check($sformatf("t3_tx%0d", i), txq[i], 24'h720000);
        end
        check("t3_flags", {busy, done, nack_err, fail}, 4'b0011);

        // 4: hpd drops during the register byte of entry 5
        txq.delete();
        mode = 0;
        pulse_start();
        repeat (3) @(negedge clk);
        check("t4_flags_cleared", {busy, done, nack_err, fail}, 4'b1000);
        for (int i = 0; i < 20000; i++) begin
            if (txq.size() == 5 && in_txn && bytec == 1) break;
            @(negedge clk);
        end
        check("t4_reached_entry5", {in_txn, 8'(bytec), 8'(txq.size())}, {1'b1, 8'd1, 8'd5});
        hpd = 1'b0;
        wait_idle("t4", 5000);
        check("t4_ntx", txq.size(), 6);
        if (txq.size() == 6) check("t4_last_tx", txq[5], 24'h72A2A4);
        check("t4_flags", {busy, done, fail}, 3'b000);
        check("t4_lines", {scl_oe, sda_oe}, 2'b00);

        // 4b/5: hpd rises again -> full run from entry 0; start pulse mid-run ignored
        txq.delete();
        hpd = 1'b1;
        repeat (1000) @(negedge clk);
        check("t5_busy_mid_run", busy, 1'b1);
        pulse_start();
        wait_idle("t5", 20000);
        exp_run(-1);
        cmp_txns("t5");
        check("t5_flags", {busy, done, nack_err, fail}, 4'b0100);

        // 5b: start after done -> full rerun
        txq.delete();
        pulse_start();
        wait_idle("t5b", 20000);
        cmp_txns("t5b");
        check("t5b_flags", {busy, done}, 2'b01);
        check("framing_violations", fviol, 0);
        check("scl_timing_violations", tviol, 0);

        // 6: asynchronous reset with both lines driven
        tchk_en = 1'b0;
        pulse_start();
        for (int i = 0; i < 2000; i++) begin
            if (scl_oe && sda_oe) break;
            @(negedge clk);
        end
        check("t6_lines_driven", {scl_oe, sda_oe}, 2'b11);
        #2 reset_n = 1'b0;
        #1 check("t6_async_release", {scl_oe, sda_oe, busy}, 3'b000);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
